// File: rtl/ms_countdown_timer.sv
// ms_countdown_timer
//   Two-digit BCD countdown (00..99 s) driven by 1 ms tick pulses. The tick
//   source is enabled only while counting. Produces BCD digits for the display
//   and a one-cycle expiry pulse when the count reaches 00.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      pulse: load load_tens/load_ones (digits >9 clamp to 9) and count
//   abort      pulse: stop and return to IDLE, digits hold for display
//   pause      level: hold the countdown while high
//   load_tens  BCD tens digit of the start value
//   load_ones  BCD ones digit of the start value
//   tick_1ms   one-cycle pulse from the 1 ms tick generator
//   timer_en   enable to the 1 ms tick generator (high only in RUN)
//   sec_tens   current BCD tens digit
//   sec_ones   current BCD ones digit
//   busy       high in RUN or PAUSE
//   expired    one-cycle pulse after entering DONE
//
// state | meaning
// IDLE  | stopped, digits hold last value
// RUN   | counting ticks, tick source enabled
// PAUSE | countdown held, tick source disabled
// DONE  | reached 00, waiting for start or abort

module ms_countdown_timer #(
    parameter int MS_PER_SEC = 1000,
    parameter int MS_W       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       tick_1ms,
    output logic       timer_en,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       busy,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);

    state_t          state;
    state_t          state_nxt;
    logic [MS_W-1:0] ms_cnt;
    logic [MS_W-1:0] ms_cnt_nxt;
    logic [3:0]      tens_nxt;
    logic [3:0]      ones_nxt;
    logic            timer_en_nxt;
    logic            busy_nxt;
    logic            expired_nxt;

    logic [3:0]      clamp_tens;
    logic [3:0]      clamp_ones;
    logic            load_zero;
    logic            ms_last;
    logic            sec_last;
    logic            tick_step;

    assign clamp_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;
    assign clamp_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;
    assign load_zero  = (clamp_tens == 4'd0) && (clamp_ones == 4'd0);
    assign ms_last    = (ms_cnt == MS_LAST);
    // RUN never holds 00, so 01 is the only value that decrements to 00
    assign sec_last   = (sec_tens == 4'd0) && (sec_ones == 4'd1);
    // a tick only counts in RUN when no higher-priority control is present
    assign tick_step  = (state == RUN) && !abort && !start && !pause && tick_1ms;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic: abort > start > pause > tick
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = load_zero ? DONE : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (tick_1ms && ms_last && sec_last) begin
                        state_nxt = DONE;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // output / datapath next values, registered below
    always_comb begin
        ms_cnt_nxt = ms_cnt;
        tens_nxt   = sec_tens;
        ones_nxt   = sec_ones;
        if (abort) begin
            ms_cnt_nxt = '0;
        end else if (start) begin
            ms_cnt_nxt = '0;
            tens_nxt   = clamp_tens;
            ones_nxt   = clamp_ones;
        end else if (tick_step) begin
            if (ms_last) begin
                ms_cnt_nxt = '0;
                if (sec_ones == 4'd0) begin
                    ones_nxt = 4'd9;
                    tens_nxt = sec_tens - 4'd1;
                end else begin
                    ones_nxt = sec_ones - 4'd1;
                end
            end else begin
                ms_cnt_nxt = ms_cnt + MS_W'(1);
            end
        end

        timer_en_nxt = (state_nxt == RUN);
        busy_nxt     = (state_nxt == RUN) || (state_nxt == PAUSE);
        // fires on entry to DONE; a start that reloads 00 counts as a new entry
        expired_nxt  = (state_nxt == DONE) && ((state != DONE) || start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_cnt   <= '0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            timer_en <= 1'b0;
            busy     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            ms_cnt   <= ms_cnt_nxt;
            sec_tens <= tens_nxt;
            sec_ones <= ones_nxt;
            timer_en <= timer_en_nxt;
            busy     <= busy_nxt;
            expired  <= expired_nxt;
        end
    end

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Testbench for ms_countdown_timer. The stimulus process drives one cycle of
// inputs at each falling edge, advances a seconds-level reference model and
// queues the outputs expected after the next rising edge. A separate monitor
// pops one expectation per rising edge and compares.

module tb_ms_countdown_timer;

    localparam int MS = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic       tick_1ms = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       timer_en;
    logic       busy;
    logic       expired;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    ms_countdown_timer #(
        .MS_PER_SEC(MS),
        .MS_W      (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pause    (pause),
        .load_tens(load_tens),
        .load_ones(load_ones),
        .tick_1ms (tick_1ms),
        .timer_en (timer_en),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .busy     (busy),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       te;
        logic       bz;
        logic       ex;
        logic [3:0] t;
        logic [3:0] o;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc_n  = 0;

    // reference model: remaining whole seconds, ms ticks into the current second
    int   m_mode = M_IDLE;
    int   m_secs = 0;
    int   m_ms   = 0;
    bit   m_exp  = 1'b0;

    function automatic obs_t model_obs();
        obs_t r;
        r.te = (m_mode == M_RUN);
        r.bz = (m_mode == M_RUN) || (m_mode == M_HOLD);
        r.ex = m_exp;
        r.t  = 4'(m_secs / 10);
        r.o  = 4'(m_secs % 10);
        return r;
    endfunction

    function automatic obs_t dut_obs();
        obs_t r;
        r.te = timer_en;
        r.bz = busy;
        r.ex = expired;
        r.t  = sec_tens;
        r.o  = sec_ones;
        return r;
    endfunction

    function automatic void model_step(bit s, bit a, bit p, int lt, int lo, bit tk);
        m_exp = 1'b0;
        if (a) begin
            m_mode = M_IDLE;
            m_ms   = 0;
        end else if (s) begin
            m_secs = ((lt > 9) ? 9 : lt) * 10 + ((lo > 9) ? 9 : lo);
            m_ms   = 0;
            if (m_secs == 0) begin
                m_mode = M_DONE;
                m_exp  = 1'b1;
            end else begin
                m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (p) begin
                m_mode = M_HOLD;
            end else if (tk) begin
                m_ms = m_ms + 1;
                if (m_ms == MS) begin
                    m_ms   = 0;
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_mode = M_DONE;
                        m_exp  = 1'b1;
                    end
                end
            end
        end else if (m_mode == M_HOLD && !p) begin
            m_mode = M_RUN;
        end
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t want);
        checks++;
        if (act === want) begin
            passed++;
        end else begin
            $display("FAIL %s: got te=%0b busy=%0b exp=%0b digits=%0h%0h, want te=%0b busy=%0b exp=%0b digits=%0h%0h",
                     name, act.te, act.bz, act.ex, act.t, act.o,
                     want.te, want.bz, want.ex, want.t, want.o);
        end
    endtask

    // one clock of stimulus
    task automatic cyc(input bit s, input bit a, input bit p, input int lt, input int lo, input bit tk);
        @(negedge clk);
        start     = s;
        abort     = a;
        pause     = p;
        load_tens = 4'(lt);
        load_ones = 4'(lo);
        tick_1ms  = tk;
        model_step(s, a, p, lt, lo, tk);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            idle(gap);
        end
    endtask

    // reset asserted between edges, checked immediately, held across one edge
    task automatic do_reset();
        obs_t zero;
        zero = '0;
        @(negedge clk);
        start = 0; abort = 0; pause = 0; tick_1ms = 0;
        load_tens = 4'd0; load_ones = 4'd0;
        #2 rst = 1'b1;
        #1 check("async reset", dut_obs(), zero);
        m_mode = M_IDLE; m_secs = 0; m_ms = 0; m_exp = 1'b0;
        exp_q.push_back(model_obs());
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // monitor
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_n++;
                check($sformatf("cycle %0d", cyc_n), dut_obs(), e);
            end
        end
    end

    initial begin
        obs_t zero;
        bit   p;
        zero = '0;
        #3 check("reset state", dut_obs(), zero);
        #4 rst = 1'b0;

        // 03 countdown, ticks every 5 cycles
        cyc(1, 0, 0, 0, 3, 0);
        ticks(12, 4);
        idle(4);

        // 10 -> 09 borrow, then on to 00
        cyc(1, 0, 0, 1, 0, 0);
        ticks(40, 1);
        idle(3);

        // pause freezes count, ticks during pause are ignored
        cyc(1, 0, 0, 0, 2, 0);
        ticks(2, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, (i % 2) == 1);
        cyc(0, 0, 0, 0, 0, 1);
        ticks(2, 2);
        idle(2);
        ticks(6, 1);
        idle(3);

        // zero load, then clamped load
        cyc(1, 0, 0, 0, 0, 0);
        idle(4);
        cyc(1, 0, 0, 15, 10, 0);
        ticks(5, 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);

        // abort beats start; restart mid-count clears the ms progress
        cyc(1, 0, 0, 0, 5, 0);
        ticks(2, 1);
        cyc(1, 1, 0, 0, 5, 1);
        idle(3);
        cyc(1, 0, 0, 0, 5, 0);
        ticks(3, 1);
        cyc(1, 0, 0, 0, 5, 0);
        ticks(3, 1);
        ticks(2, 1);
        idle(2);

        // async reset mid-run, then a normal countdown
        cyc(1, 0, 0, 0, 9, 0);
        ticks(5, 1);
        do_reset();
        cyc(1, 0, 0, 0, 2, 0);
        ticks(9, 1);
        idle(3);

        // randomized traffic
        p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                p = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) p = !p;
                cyc($urandom_range(0, 29) == 0,
                    $urandom_range(0, 149) == 0,
                    p,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
                    int'($urandom_range(0, 15)),
                    $urandom_range(0, 2) == 0);
            end
        end
        idle(2);

        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ms_countdown_timer.md
Name: ms_countdown_timer

Overview:
Downstream consumer of the 1 ms LFSR tick generator. It counts 1 ms tick pulses into seconds and runs a loadable two-digit BCD countdown from 00 to 99 seconds. It drives the tick generator's enable, so the tick source runs only while the countdown is active. It outputs BCD digits for the 7-segment display path and a one-cycle expiry pulse for the game-control FSM.

Parameters:
MS_PER_SEC, 1000, number of tick_1ms pulses per decremented second (benches use 4)
MS_W, 10, width of the internal millisecond counter; must satisfy 2^MS_W >= MS_PER_SEC

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: load load_tens/load_ones and begin counting
abort  input  1  one-cycle pulse: stop and return to IDLE
pause  input  1  level: hold the countdown while high
load_tens  input  4  BCD tens digit of the start value
load_ones  input  4  BCD ones digit of the start value
tick_1ms  input  1  one-cycle pulse from the 1 ms LFSR timer
timer_en  output  1  enable to the 1 ms LFSR timer
sec_tens  output  4  current BCD tens digit
sec_ones  output  4  current BCD ones digit
busy  output  1  high in RUN or PAUSE
expired  output  1  one-cycle pulse when the count reaches 00

Behaviour:
- Reset (async, rst=1): state=IDLE, ms_cnt=0, sec_tens=0, sec_ones=0, timer_en=0, busy=0, expired=0. All outputs are registered.
- States: IDLE, RUN, PAUSE, DONE.
- Signal priority within a cycle: abort > start > pause > tick_1ms.
- IDLE/DONE + start:
  - Load the digits; any digit >9 is clamped to 9. ms_cnt=0.
  - If the loaded value is 00: go to DONE and assert expired the next cycle.
  - Otherwise go to RUN.
- RUN: timer_en=1, busy=1.
  - tick_1ms with ms_cnt < MS_PER_SEC-1: ms_cnt increments.
  - tick_1ms with ms_cnt == MS_PER_SEC-1: ms_cnt=0 and the BCD value decrements by 1.
    - ones==0 wraps to 9 and tens decrements; there is no wrap below 00.
    - If the value becomes 00: state=DONE, expired=1 for exactly one cycle, timer_en=0 on the same edge.
- RUN + pause=1 (no abort/start): go to PAUSE; a tick in the same cycle is ignored.
- PAUSE: timer_en=0, busy=1, ms_cnt holds, digits hold. Deasserting timer_en resets the LFSR, so the partial ms in flight is discarded (accepted, at most 1 ms error). pause=0 returns to RUN.
- RUN/PAUSE + start: reload and restart (ms_cnt=0, state RUN), same rules as from IDLE.
- Any state + abort: IDLE, ms_cnt=0, timer_en=0, busy=0. Digits hold their last value for display.
- DONE: digits stay 00, busy=0, timer_en=0 until start or abort.
- tick_1ms in IDLE/PAUSE/DONE is ignored.
- expired is high only in the cycle after the transition into DONE; it never re-fires while in DONE.
- Reset mid-count clears everything immediately; a tick on the reset edge is lost.
- Latency: digit outputs update on the clock edge that samples the terminal tick (1 cycle after the tick is presented).

Test Plan:
- MS_PER_SEC=4, load 0/3, start, 12 ticks spaced 5 cycles apart -> digits 03,02,01,00 after ticks 4/8/12; expired high for exactly 1 cycle after tick 12; busy and timer_en low afterwards.
- Load 1/0, start, 4 ticks -> digits go 10 -> 09 (tens borrow); then continue to 00 and check the expired pulse.
- Load 0/2, run 2 ticks, raise pause for 20 cycles while injecting ticks -> ms_cnt and digits frozen, timer_en=0; release pause, 2 more ticks -> digits 01.
- Load 0/0, start -> DONE, expired pulses once, no RUN; load 0xF/0xA, start -> digits 99.
- Mid-RUN (digits 05): abort and start in the same cycle -> IDLE, digits hold 05, busy=0. Then a restart mid-count reloads the value and clears ms_cnt.
- Assert rst asynchronously between clock edges during RUN -> all outputs 0 immediately; start after release -> normal countdown.
